// File: rtl/mux_sel_debounce.sv
// Push-button select generator: 2-FF synchroniser, debounce FSM, and toggling mux select S.
// Optional periodic auto-toggle is compiled in with `define AUTO_TOGGLE_EN.
module mux_sel_debounce #(
    parameter int DB_CYCLES   = 1000000,
    parameter int CNT_W       = 20,
    parameter int AUTO_PERIOD = 100000000,
    parameter int AUTO_W      = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic auto_en,
    output logic S,
    output logic sel_chg,
    output logic db_level
);

    typedef enum logic [1:0] {IDLE, ARM_HI, HIGH, ARM_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             sync_q;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             press;
    logic             auto_hit;
    logic             toggle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_q <= btn;
            btn_s  <= sync_q;
        end
    end

    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (btn_s)         state_nxt = ARM_HI;
            ARM_HI:  if (!btn_s)        state_nxt = IDLE;
                     else if (cnt_done) state_nxt = HIGH;
            HIGH:    if (!btn_s)        state_nxt = ARM_LO;
            ARM_LO:  if (btn_s)         state_nxt = HIGH;
                     else if (cnt_done) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        db_level = (state == HIGH) || (state == ARM_LO);
        press    = (state == ARM_HI) && (state_nxt == HIGH);
    end

    // Counter runs only while arming and restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if ((state_nxt != state) || !((state == ARM_HI) || (state == ARM_LO)))
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

`ifdef AUTO_TOGGLE_EN
    logic [AUTO_W-1:0] timer;

    // Press takes precedence so a coincident expiry never double-toggles S.
    assign auto_hit = auto_en && (state == IDLE) && (timer == AUTO_W'(AUTO_PERIOD - 1)) && !press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (!auto_en || (state != IDLE) || press || auto_hit)
            timer <= '0;
        else
            timer <= timer + AUTO_W'(1);
    end
`else
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
    assign auto_hit       = 1'b0;
`endif

    assign toggle = press || auto_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S       <= 1'b0;
            sel_chg <= 1'b0;
        end else begin
            S       <= S ^ toggle;
            sel_chg <= toggle;
        end
    end

endmodule
